// File: rtl/bp_be_issue_queue_pkg.sv
// bp_be_issue_queue_pkg: width helpers and status type shared by the issue queue and its checker
package bp_be_issue_queue_pkg;

    localparam int iq_cnt_max_width_lp = 16;

    function automatic int ptr_width_f(int els);
        return $clog2(els) + 1;
    endfunction

    function automatic int cnt_width_f(int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic                           full;
        logic                           empty;
        logic [iq_cnt_max_width_lp-1:0] spec_cnt;
        logic [iq_cnt_max_width_lp-1:0] occ_cnt;
    } iq_status_s;

endpackage

// File: rtl/bp_be_issue_queue_if.sv
// bp_be_issue_queue_if: FE-side enqueue, BE-side issue/commit and status signals of the issue queue
interface bp_be_issue_queue_if #(
    parameter int entry_width_p = 128,
    parameter int els_p         = 16,
    parameter int deq_width_p   = 2
);
    import bp_be_issue_queue_pkg::*;

    localparam int cnt_width_lp     = cnt_width_f(els_p);
    localparam int deq_cnt_width_lp = cnt_width_f(deq_width_p);

    logic [entry_width_p-1:0]    enq_data_i;
    logic                        enq_v_i;
    logic                        enq_ready_o;
    logic [entry_width_p-1:0]    issue_data_o;
    logic                        issue_v_o;
    logic                        issue_yumi_i;
    logic [deq_cnt_width_lp-1:0] deq_cnt_i;
    logic                        roll_i;
    logic                        clr_i;
    logic                        full_o;
    logic                        empty_o;
    logic [cnt_width_lp-1:0]     spec_cnt_o;
    logic [cnt_width_lp-1:0]     occ_cnt_o;

    modport master (
        output enq_data_i, enq_v_i, issue_yumi_i, deq_cnt_i, roll_i, clr_i,
        input  enq_ready_o, issue_data_o, issue_v_o, full_o, empty_o, spec_cnt_o, occ_cnt_o
    );

    modport slave (
        input  enq_data_i, enq_v_i, issue_yumi_i, deq_cnt_i, roll_i, clr_i,
        output enq_ready_o, issue_data_o, issue_v_o, full_o, empty_o, spec_cnt_o, occ_cnt_o
    );

endinterface

// File: rtl/bp_be_issue_queue_ptr.sv
// bp_be_issue_queue_ptr: wrap-bit queue pointer with increment-by-N and a priority load
module bp_be_issue_queue_ptr #(
    parameter int ptr_width_p = 5,
    parameter int inc_width_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [inc_width_p-1:0] inc_i,
    input  logic                   load_v_i,
    input  logic [ptr_width_p-1:0] load_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    logic [ptr_width_p-1:0] ptr_d, ptr_q;

    // load wins over increment; the wrap bit rolls naturally modulo 2*els
    always_comb ptr_d = load_v_i ? load_i : ptr_q + ptr_width_p'(inc_i);

    // pointer register, cleared asynchronously
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: speculative FE packet queue with issue, multi-entry commit, roll and clear
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter int entry_width_p = 128,
    parameter int els_p         = 16,
    parameter int deq_width_p   = 2
) (
    input logic             clk_i,
    input logic             reset_n_i,
    bp_be_issue_queue_if.slave q
);

    localparam int idx_width_lp     = $clog2(els_p);
    localparam int ptr_width_lp     = ptr_width_f(els_p);
    localparam int cnt_width_lp     = cnt_width_f(els_p);
    localparam int deq_cnt_width_lp = cnt_width_f(deq_width_p);

    logic [ptr_width_lp-1:0]  wptr, rptr, cptr, rptr_load, issued;
    logic [entry_width_p-1:0] mem_q [els_p];
    logic                     enq_fire;

    assign enq_fire  = q.enq_v_i & q.enq_ready_o & ~q.clr_i;
    assign rptr_load = q.clr_i ? wptr : cptr + ptr_width_lp'(q.deq_cnt_i);
    assign issued    = rptr - cptr;

    bp_be_issue_queue_ptr #(.ptr_width_p(ptr_width_lp), .inc_width_p(1)) wptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(enq_fire),
        .load_v_i(1'b0), .load_i('0), .ptr_o(wptr)
    );

    bp_be_issue_queue_ptr #(.ptr_width_p(ptr_width_lp), .inc_width_p(1)) rptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(q.issue_yumi_i),
        .load_v_i(q.clr_i | q.roll_i), .load_i(rptr_load), .ptr_o(rptr)
    );

    bp_be_issue_queue_ptr #(.ptr_width_p(ptr_width_lp), .inc_width_p(deq_cnt_width_lp)) cptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(q.deq_cnt_i),
        .load_v_i(q.clr_i), .load_i(wptr), .ptr_o(cptr)
    );

    // packet storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[wptr[idx_width_lp-1:0]] <= q.enq_data_i;
    end

    assign q.full_o       = (wptr ^ cptr) == ptr_width_lp'(els_p);
    assign q.enq_ready_o  = ~q.full_o;
    assign q.empty_o      = wptr == cptr;
    assign q.issue_v_o    = rptr != wptr;
    assign q.issue_data_o = mem_q[rptr[idx_width_lp-1:0]];
    assign q.spec_cnt_o   = cnt_width_lp'(wptr - rptr);
    assign q.occ_cnt_o    = cnt_width_lp'(wptr - cptr);

    a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !q.clr_i |-> !(q.issue_yumi_i && !q.issue_v_o));
    a_deq_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !q.clr_i |-> ptr_width_lp'(q.deq_cnt_i) <= issued);
    a_deq_width: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        q.deq_cnt_i <= deq_cnt_width_lp'(deq_width_p));

endmodule
